// File: rtl/memory_pkg.sv
// Shared encodings for the MFA/MFC memory responder: access sizes,
// read/write direction, FSM states and address/size helpers.
package memory_pkg;

    typedef enum logic [1:0] {
        MAS_BYTE = 2'b00,
        MAS_HALF = 2'b01,
        MAS_WORD = 2'b10,
        MAS_RSVD = 2'b11
    } mas_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Number of bytes moved by an access; reserved size moves nothing.
    function automatic logic [2:0] mas_bytes(input mas_e mas);
        case (mas)
            MAS_BYTE: mas_bytes = 3'd1;
            MAS_HALF: mas_bytes = 3'd2;
            MAS_WORD: mas_bytes = 3'd4;
            default:  mas_bytes = 3'd0;
        endcase
    endfunction

    // Misaligned requests are silently aligned down, never faulted.
    function automatic logic [31:0] align_addr(input logic [31:0] addr, input mas_e mas);
        case (mas)
            MAS_HALF: align_addr = {addr[31:1], 1'b0};
            MAS_WORD: align_addr = {addr[31:2], 2'b00};
            default:  align_addr = addr;
        endcase
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// MFA/MFC handshake bundle between the control unit (master) and memory (slave).
interface memory_responder_if;
    logic        mfa;
    logic        rw;
    logic [1:0]  mas;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mfc;

    modport master (
        output mfa, rw, mas, addr, data_in,
        input  data_out, mfc
    );

    modport slave (
        input  mfa, rw, mas, addr, data_in,
        output data_out, mfc
    );
endinterface

// File: rtl/mem_wait_counter.sv
// 4-bit loadable down-counter that paces the memory access latency.
module mem_wait_counter (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       enable,
    output logic       zero
);
    logic [3:0] count_reg;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign zero = (count_reg == 4'd0);
endmodule

// File: rtl/memory_responder.sv
// Big-endian byte memory answering the MFA/MFC handshake after a fixed latency.
module memory_responder
    import memory_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic clr,
    memory_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    state_e          state_reg, state_next;
    logic            req_rw_reg;
    mas_e            req_mas_reg;
    logic [AW-1:0]   req_addr_reg;
    logic [31:0]     req_data_reg;
    logic [31:0]     data_out_reg;
    logic [7:0]      mem [DEPTH];

    logic            accept;
    logic            access;
    logic            cnt_zero;
    logic [31:0]     aligned_addr;
    logic            unused_addr_hi;

    logic [AW-1:0]   lane_addr  [4];
    logic            lane_we    [4];
    logic [7:0]      lane_wdata [4];
    logic [7:0]      lane_rdata [4];
    logic [31:0]     wdata_left;
    logic [31:0]     read_word;

    assign accept = (state_reg == IDLE) && bus.mfa;
    assign access = (state_reg == BUSY) && cnt_zero;

    assign aligned_addr   = align_addr(bus.addr, mas_e'(bus.mas));
    assign unused_addr_hi = ^aligned_addr[31:AW];

    mem_wait_counter u_wait (
        .clk        (clk),
        .clr        (clr),
        .load       (accept),
        .load_value (4'(LATENCY - 1)),
        .enable     (state_reg == BUSY),
        .zero       (cnt_zero)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: accept in IDLE, wait out the latency, hold DONE while MFA stays high.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.mfa)   state_next = BUSY;
            BUSY:    if (cnt_zero)  state_next = DONE;
            DONE:    if (!bus.mfa)  state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Capture the request once; input changes afterwards are ignored.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            req_rw_reg   <= RW_READ;
            req_mas_reg  <= MAS_BYTE;
            req_addr_reg <= '0;
            req_data_reg <= 32'h0;
        end else if (accept) begin
            req_rw_reg   <= bus.rw;
            req_mas_reg  <= mas_e'(bus.mas);
            req_addr_reg <= aligned_addr[AW-1:0];
            req_data_reg <= bus.data_in;
        end
    end

    // Left-justify write data so lane 0 always carries the most significant byte.
    always_comb begin
        case (req_mas_reg)
            MAS_BYTE: wdata_left = {req_data_reg[7:0], 24'h0};
            MAS_HALF: wdata_left = {req_data_reg[15:0], 16'h0};
            MAS_WORD: wdata_left = req_data_reg;
            default:  wdata_left = 32'h0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_addr[gi]  = req_addr_reg + AW'(gi);
            assign lane_we[gi]    = (3'(gi) < mas_bytes(req_mas_reg));
            assign lane_wdata[gi] = wdata_left[31 - 8*gi -: 8];
            assign lane_rdata[gi] = mem[lane_addr[gi]];
        end
    endgenerate

    // Assemble zero-extended read data, most significant byte at the lowest address.
    always_comb begin
        case (req_mas_reg)
            MAS_BYTE: read_word = {24'h0, lane_rdata[0]};
            MAS_HALF: read_word = {16'h0, lane_rdata[0], lane_rdata[1]};
            MAS_WORD: read_word = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};
            default:  read_word = 32'h0;
        endcase
    end

    // Commit write bytes only on the BUSY->DONE edge; contents survive clr.
    always_ff @(posedge clk) begin
        if (access && req_rw_reg == RW_WRITE) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    mem[lane_addr[i]] <= lane_wdata[i];
                end
            end
        end
    end

    // Read data updates only when a read completes and holds otherwise.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_out_reg <= 32'h0;
        end else if (access && req_rw_reg == RW_READ) begin
            data_out_reg <= read_word;
        end
    end

    assign bus.mfc      = (state_reg == DONE);
    assign bus.data_out = data_out_reg;
endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: two instances (latency 2 and 4).
module tb_memory_responder;
    import memory_pkg::*;

    logic clk;
    logic clr_a, clr_b;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] exp_q [$];

    memory_responder_if bus_a ();
    memory_responder_if bus_b ();

    memory_responder #(.DEPTH(256), .LATENCY(2)) dut_a (
        .clk (clk),
        .clr (clr_a),
        .bus (bus_a.slave)
    );

    memory_responder #(.DEPTH(256), .LATENCY(4)) dut_b (
        .clk (clk),
        .clr (clr_b),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int sel, input logic mfa, input logic rw,
                         input logic [1:0] mas, input logic [31:0] addr,
                         input logic [31:0] data);
        if (sel == 0) begin
            bus_a.mfa = mfa; bus_a.rw = rw; bus_a.mas = mas;
            bus_a.addr = addr; bus_a.data_in = data;
        end else begin
            bus_b.mfa = mfa; bus_b.rw = rw; bus_b.mas = mas;
            bus_b.addr = addr; bus_b.data_in = data;
        end
    endtask

    function automatic logic mfc_of(input int sel);
        return (sel == 0) ? bus_a.mfc : bus_b.mfc;
    endfunction

    function automatic logic [31:0] dout_of(input int sel);
        return (sel == 0) ? bus_a.data_out : bus_b.data_out;
    endfunction

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 2 : 4;
    endfunction

    // One complete handshake; expected data_out is queued at issue and checked at MFC.
    task automatic run_txn(input int sel, input string name, input logic rw,
                           input logic [1:0] mas, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_dout,
                           input int hold);
        int n;
        logic [31:0] exp;
        logic [31:0] got;
        @(negedge clk);
        drive(sel, 1'b1, rw, mas, addr, data);
        exp_q.push_back(exp_dout);
        @(posedge clk);
        #1;
        // Request is latched now; scramble everything but MFA.
        drive(sel, 1'b1, ~rw, ~mas, ~addr, ~data);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mfc_of(sel) && n < 40);
        checks++;
        if (n != lat_of(sel) || !mfc_of(sel)) begin
            failures++;
            $display("FAIL %s latency: got %0d edges (mfc=%b), required %0d", name, n, mfc_of(sel), lat_of(sel));
        end
        exp = exp_q.pop_front();
        got = dout_of(sel);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s data_out: got %h, required %h", name, got, exp);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checks++;
            if (mfc_of(sel) !== 1'b1) begin
                failures++;
                $display("FAIL %s hold cycle %0d: mfc got %b, required 1", name, h, mfc_of(sel));
            end
        end
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        checks++;
        if (mfc_of(sel) !== 1'b0) begin
            failures++;
            $display("FAIL %s release: mfc got %b, required 0", name, mfc_of(sel));
        end
        $display("txn %s: latency=%0d data_out=%h expected=%h", name, n, got, exp);
    endtask

    task automatic test_reset;
        int bad;
        clr_a = 1'b0;
        clr_b = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr_a = 1'b1;
        clr_b = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus_a.mfc !== 1'b0 || bus_a.data_out !== 32'h0 ||
                bus_b.mfc !== 1'b0 || bus_b.data_out !== 32'h0) begin
                failures++;
                bad++;
                $display("FAIL reset_idle cycle %0d: mfc_a=%b dout_a=%h mfc_b=%b dout_b=%h, required 0/0", i,
                         bus_a.mfc, bus_a.data_out, bus_b.mfc, bus_b.data_out);
            end
        end
        $display("txn reset_idle: 10 idle cycles, %0d bad", bad);
    endtask

    task automatic test_word_rw;
        run_txn(0, "wr_word_10", RW_WRITE, MAS_WORD, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        run_txn(0, "rd_word_10", RW_READ,  MAS_WORD, 32'h10, 32'h0, 32'hDEADBEEF, 5);
        run_txn(0, "rd_byte_11", RW_READ,  MAS_BYTE, 32'h11, 32'h0, 32'h000000AD, 0);
    endtask

    task automatic test_halfword_align;
        run_txn(0, "wr_half_22", RW_WRITE, MAS_HALF, 32'h22, 32'h0000BEEF, 32'h000000AD, 0);
        run_txn(0, "wr_half_21", RW_WRITE, MAS_HALF, 32'h21, 32'hFFFF1234, 32'h000000AD, 0);
        run_txn(0, "rd_word_20", RW_READ,  MAS_WORD, 32'h20, 32'h0, 32'h1234BEEF, 0);
        run_txn(0, "rd_half_23", RW_READ,  MAS_HALF, 32'h23, 32'h0, 32'h0000BEEF, 0);
        run_txn(0, "wr_byte_13", RW_WRITE, MAS_BYTE, 32'h13, 32'hAABBCC55, 32'h0000BEEF, 0);
        run_txn(0, "rd_word_10b", RW_READ, MAS_WORD, 32'h10, 32'h0, 32'hDEADBE55, 0);
    endtask

    task automatic test_wrap_reserved;
        run_txn(0, "wr_word_wrap", RW_WRITE, MAS_WORD, 32'h104, 32'hCAFEF00D, 32'hDEADBE55, 0);
        run_txn(0, "rd_word_04",   RW_READ,  MAS_WORD, 32'h4,   32'h0, 32'hCAFEF00D, 0);
        run_txn(0, "rd_byte_wrap", RW_READ,  MAS_BYTE, 32'h107, 32'h0, 32'h0000000D, 0);
        run_txn(0, "wr_rsvd",      RW_WRITE, MAS_RSVD, 32'h4,   32'hFFFFFFFF, 32'h0000000D, 0);
        run_txn(0, "rd_rsvd",      RW_READ,  MAS_RSVD, 32'h4,   32'h0, 32'h0, 0);
        run_txn(0, "rd_word_04b",  RW_READ,  MAS_WORD, 32'h4,   32'h0, 32'hCAFEF00D, 0);
    endtask

    task automatic test_back_to_back;
        run_txn(0, "b2b_rd_20", RW_READ, MAS_WORD, 32'h20, 32'h0, 32'h1234BEEF, 0);
        run_txn(0, "b2b_rd_12", RW_READ, MAS_HALF, 32'h12, 32'h0, 32'h0000BE55, 0);
    endtask

    task automatic test_reset_in_done;
        int n;
        @(negedge clk);
        drive(0, 1'b1, RW_READ, MAS_WORD, 32'h4, 32'h0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus_a.mfc && n < 40);
        checks++;
        if (bus_a.mfc !== 1'b1 || bus_a.data_out !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL done_reset pre: mfc=%b dout=%h, required 1/cafef00d", bus_a.mfc, bus_a.data_out);
        end
        @(negedge clk);
        clr_a = 1'b0;
        #1;
        checks++;
        if (bus_a.mfc !== 1'b0 || bus_a.data_out !== 32'h0) begin
            failures++;
            $display("FAIL done_reset async: mfc=%b dout=%h, required 0/0", bus_a.mfc, bus_a.data_out);
        end
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        clr_a = 1'b1;
        $display("txn done_reset: mfc=%b data_out=%h after clr", bus_a.mfc, bus_a.data_out);
        run_txn(0, "rd_after_clr", RW_READ, MAS_WORD, 32'h104, 32'h0, 32'hCAFEF00D, 0);
    endtask

    task automatic test_reset_in_busy;
        int rose;
        run_txn(1, "b_wr_40", RW_WRITE, MAS_WORD, 32'h40, 32'h11223344, 32'h0, 0);
        @(negedge clk);
        drive(1, 1'b1, RW_WRITE, MAS_WORD, 32'h40, 32'hFFFFFFFF);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        clr_b = 1'b0;
        @(negedge clk);
        clr_b = 1'b1;
        rose = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus_b.mfc !== 1'b0) rose++;
        end
        checks++;
        if (rose != 0) begin
            failures++;
            $display("FAIL busy_reset mfc: rose in %0d cycles, required 0", rose);
        end
        $display("txn busy_reset: mfc high cycles=%0d", rose);
        run_txn(1, "b_rd_40", RW_READ, MAS_WORD, 32'h40, 32'h0, 32'h11223344, 2);
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_halfword_align();
        test_wrap_reserved();
        test_back_to_back();
        test_reset_in_done();
        test_reset_in_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_responder.md
# memory_responder

Byte-addressable memory that answers the control unit's MFA/MFC memory handshake. It latches the request (address, R/W, MAS, write data) when MFA is sampled high and waits a programmable number of cycles. It then performs the access and asserts MFC until the control unit releases MFA. It sits between the datapath's MAR/MDR and the control unit's MFC input, and is the responder side of the MFA/MFC protocol.

## Interface
- DEPTH, 256, memory size in bytes; a power of two, at least 4.
- LATENCY, 2, number of clock cycles from MFA being sampled to MFC rising; legal range 1..15.
- clk  input  1  system clock; all state changes on posedge.
- clr  input  1  asynchronous, active-low reset.
- mfa  input  1  memory function activate; request strobe from the control unit.
- rw  input  1  0 = read, 1 = write.
- mas  input  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- addr  input  32  byte address; only addr[log2(DEPTH)-1:0] is used.
- data_in  input  32  write data; byte uses [7:0], halfword uses [15:0].
- data_out  output  32  read data, zero-extended.
- mfc  output  1  memory function complete.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - mfc=0.
  - When mfa=1 at a posedge, capture addr, rw, mas and data_in into request registers.
  - Load the wait counter with LATENCY-1 and go to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter reaches 0, perform the access and go to DONE.
  - Changes on the inputs during BUSY are ignored; the captured request is used.
- DONE:
  - mfc=1.
  - Stay while mfa=1; return to IDLE on the first posedge with mfa=0.
  - If mfa is already 0 on entry, mfc is high for exactly one cycle.
- Addressing:
  - Big-endian: word at A is mem[A]→[31:24], mem[A+1]→[23:16], mem[A+2]→[15:8], mem[A+3]→[7:0].
  - Halfword at A uses mem[A] as the most significant byte.
  - Alignment is forced by clearing low bits: addr[0] for halfword, addr[1:0] for word. No fault is raised.
  - Addresses wrap modulo DEPTH.
- Read: data_out is loaded at the BUSY→DONE transition and holds until the next read completes. Writes do not change data_out.
- Write: memory bytes are committed at the BUSY→DONE edge, and only that edge.
- mas=11: no write is performed; a read returns data_out=0. MFC is still completed normally.
- Memory contents are zero at power-up and are not cleared by clr.

## Timing
- Reset (clr=0): state is IDLE, mfc=0, data_out=32'h0 and the counter is 0. Reset takes effect immediately, asynchronously.
- Reset during BUSY: the request is aborted and no memory write occurs.
- Reset during DONE: the write has already been committed; mfc drops immediately.
- Latency: mfa is sampled high at edge k. mfc rises after edge k+LATENCY, and data_out is valid in that same cycle.
- Minimum spacing between transactions: after mfa falls, DONE→IDLE takes one edge, and a new mfa can be sampled on the following edge.
- A new request is never accepted in DONE; holding mfa=1 keeps mfc=1 indefinitely.
- mfa must be held at 1 through the sampling edge. Pulses shorter than one cycle that miss the edge are lost.

## Structure
- Shared package memory_pkg:
  - MAS encodings: MAS_BYTE, MAS_HALF, MAS_WORD, MAS_RSVD.
  - RW_READ and RW_WRITE constants.
  - FSM state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
- Sub-module mem_wait_counter: 4-bit loadable down-counter. It has load, load value and enable inputs, and a zero flag output; clk and clr match the parent.
- The byte array, size/alignment logic and FSM live in memory_responder.

## Test plan
- Reset and idle: hold clr=0, then release with mfa=0 → mfc=0 and data_out=0 for 10 cycles.
- Word write then read (LATENCY=2):
  - Write addr=0x10, data_in=0xDEADBEEF, mas=10.
  - Then read the same address with mas=10 → mfc rises 2 edges after mfa is sampled, and data_out=0xDEADBEEF.
  - A byte read of 0x11 returns 0x000000AD.
- Halfword and alignment:
  - Write halfword 0x1234 at addr=0x21, so it is stored at 0x20.
  - A word read of 0x20 → 0x1234BEEF if 0x22..0x23 were preloaded with BE EF; otherwise 0x12340000.
- Handshake hold and release:
  - Keep mfa=1 for 5 cycles after mfc rises → mfc stays 1.
  - Drop mfa → mfc=0 one edge later, and a new request is accepted on the next edge.
- Reset mid-BUSY:
  - Set LATENCY=4 and write 0xFFFFFFFF to 0x40.
  - Pulse clr=0 one cycle after acceptance → mfc never rises, and a later read of 0x40 returns 0x00000000.
- Wrap and reserved size:
  - A word write to addr=DEPTH+0x4 lands at 0x4.
  - A mas=11 read returns data_out=0 with a normal MFC completion.
